// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_pipe data memory: access-size encoding
// and the per-size address/byte masks used by the store and alignment logic.
package dmem_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  // Address bits below the natural alignment of an access of this size.
  function automatic logic [2:0] size_lo_mask(input mem_size_e sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Byte enables of an access of this size placed at byte lane 0.
  function automatic logic [7:0] size_byte_mask(input mem_size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus of the dmem_pipe data memory, with master (requester)
// and slave (memory) views.
interface dmem_if #(
  parameter int XLEN   = dmem_pkg::XLEN_DEFAULT,
  parameter int ADDR_W = 64
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response is consumed on a rising edge where rsp_valid && rsp_ready, and it
  // stays unchanged until then. req_ready = !rsp_valid || rsp_ready.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ext.sv
// Load-path byte-lane extract: moves the addressed bytes of a memory word to the
// LSBs and sign- or zero-extends them to XLEN according to the access size.
module dmem_ext
  import dmem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      lane_i,
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = word_i >> {lane_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_B:    data_o = {{(XLEN-8){~unsigned_i & shifted[7]}},   shifted[7:0]};
      SZ_H:    data_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    data_o = {{(XLEN-32){~unsigned_i & shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// Single-cycle-latency data memory with byte/half/word/double loads and stores.
// Define DMEM_ALIGN_CHK_EN to fault misaligned accesses instead of aligning them down.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 64
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_size_e       size;
  logic [2:0]      lo_mask;
  logic [2:0]      lane;
  logic [IDX_W-1:0] idx;
  logic            oor;
  logic            misal;
  logic            fault;
  logic            accept;
  logic            wr_en;
  logic [7:0]      byte_en;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] mem_rd [DEPTH];

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q,   rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign size    = mem_size_e'(bus.req_size);
  assign lo_mask = size_lo_mask(size);
  assign idx     = bus.req_addr[IDX_W+2:3];
  assign oor     = |bus.req_addr[ADDR_W-1:IDX_W+3];

`ifdef DMEM_ALIGN_CHK_EN
  assign misal = |(bus.req_addr[2:0] & lo_mask);
  assign lane  = bus.req_addr[2:0];
`else
  assign misal = 1'b0;
  assign lane  = bus.req_addr[2:0] & ~lo_mask;
`endif

  assign fault = oor | misal;

  // Acceptance is masked during reset so a request held across reset cannot write.
  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready && rst_n;
  assign wr_en         = accept && bus.req_we && !fault;
  assign byte_en       = size_byte_mask(size) << lane;
  assign wdata_sh      = bus.req_wdata << {lane, 3'b000};

  // ---------------------------------------------------------------------------
  // Storage: one register per word, preloaded with its own index and never reset
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [XLEN-1:0] word_q = XLEN'(gi);

    always_ff @(posedge clk) begin
      if (wr_en && idx == IDX_W'(gi)) begin
        for (int b = 0; b < 8; b++) begin
          if (byte_en[b]) word_q[8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end

    assign mem_rd[gi] = word_q;
  end

  assign rd_word = mem_rd[idx];

  dmem_ext #(
    .XLEN (XLEN)
  ) u_ext (
    .word_i     (rd_word),
    .lane_i     (lane),
    .size_i     (size),
    .unsigned_i (bus.req_unsigned),
    .data_o     (ld_data)
  );

  // ---------------------------------------------------------------------------
  // Response register: a new acceptance overwrites the slot being consumed
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || bus.req_we) ? '0 : ld_data;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe: directed scenarios followed by random
// traffic, all checked against a byte-array memory model and an expected queue.
module tb_dmem_pipe;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 64;

  logic clk;
  logic rst_n;

  dmem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  dmem_pipe #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN:0] exp_q[$];          // {err, rdata} of responses still owed
  logic [7:0]    mem_b [DEPTH*8];   // byte-addressed little-endian image

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN:0] model(input bit we, input logic [63:0] addr,
                                          input logic [1:0] size, input bit uns,
                                          input logic [63:0] wdata);
    int          n;
    logic [63:0] a;
    logic [63:0] v;
    n = 1 << size;
    a = addr;
    v = '0;
    if (addr >= 64'(DEPTH * 8)) return {1'b1, 64'h0};
`ifdef DMEM_ALIGN_CHK_EN
    if ((addr % 64'(n)) != 0) return {1'b1, 64'h0};
`else
    a = addr - (addr % 64'(n));
`endif
    if (we) begin
      for (int i = 0; i < n; i++) mem_b[int'(a) + i] = wdata[8*i +: 8];
      return {1'b0, 64'h0};
    end
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[int'(a) + i];
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8*n));
    return {1'b0, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at negedge; inputs already set for the next edge)
  // ---------------------------------------------------------------------------
  task automatic step(output bit acc);
    logic [XLEN:0] e;
    bit            exp_ready;
    #1;
    exp_ready = (exp_q.size() == 0) || bus.rsp_ready;
    check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_eq("rsp_rdata", bus.rsp_rdata, e[63:0]);
      check_eq("rsp_err", 64'(bus.rsp_err), 64'(e[64]));
      if (bus.rsp_ready) void'(exp_q.pop_front());
    end
    acc = bus.req_valid && exp_ready;
    if (acc) exp_q.push_back(model(bus.req_we, bus.req_addr, bus.req_size,
                                   bus.req_unsigned, bus.req_wdata));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input bit we, input logic [63:0] addr, input logic [1:0] size,
                         input bit uns, input logic [63:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  task automatic send(input bit we, input logic [63:0] addr, input logic [1:0] size,
                      input bit uns, input logic [63:0] wdata);
    bit acc;
    acc = 1'b0;
    set_req(we, addr, size, uns, wdata);
    for (int i = 0; i < 16 && !acc; i++) step(acc);
    check_eq("accept", 64'(acc), 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(acc);
  endtask

  task automatic rand_req();
    logic [63:0] addr;
    int          r;
    r = $urandom_range(0, 9);
    if (r == 0)      addr = {$urandom, $urandom};
    else if (r == 1) addr = 64'(2048 + $urandom_range(0, 2047));
    else             addr = 64'($urandom_range(0, 2047));
    set_req(1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), {$urandom, $urandom});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit acc;

    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < 8; k++) mem_b[8*i + k] = 8'((i >> (8*k)) & 8'hFF);

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata,      64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    step(acc);

    // Double store/load round trip
    send(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788);
    send(1'b0, 64'h10, 2'd3, 1'b1, 64'h0);
    drain();

    // Byte store into a double, signed/unsigned byte loads, double reload
    send(1'b1, 64'h13, 2'd0, 1'b0, 64'h80);
    send(1'b0, 64'h13, 2'd0, 1'b0, 64'h0);
    send(1'b0, 64'h13, 2'd0, 1'b1, 64'h0);
    send(1'b0, 64'h10, 2'd3, 1'b1, 64'h0);
    drain();

    // Out-of-range store must not touch word 0
    send(1'b1, 64'h800, 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D);
    send(1'b0, 64'h0, 2'd3, 1'b1, 64'h0);
    drain();

    // Backpressure for three cycles, then back-to-back loads at 0x0 and 0x8
    bus.rsp_ready = 1'b0;
    send(1'b0, 64'h8, 2'd3, 1'b1, 64'h0);
    set_req(1'b0, 64'h0, 2'd3, 1'b1, 64'h0);
    for (int i = 0; i < 3; i++) step(acc);
    check_eq("bp_no_accept", 64'(acc), 64'd0);
    bus.rsp_ready = 1'b1;
    step(acc);
    check_eq("b2b_accept0", 64'(acc), 64'd1);
    set_req(1'b0, 64'h8, 2'd3, 1'b1, 64'h0);
    step(acc);
    check_eq("b2b_accept1", 64'(acc), 64'd1);
    drain();

    // Misaligned half load at 0x3
    send(1'b1, 64'h0, 2'd3, 1'b0, 64'h8877665544332211);
    send(1'b0, 64'h3, 2'd1, 1'b0, 64'h0);
    send(1'b0, 64'h3, 2'd1, 1'b1, 64'h0);
    drain();

    // Reset with a store response pending: response dropped, store kept
    bus.rsp_ready = 1'b0;
    send(1'b1, 64'h18, 2'd3, 1'b0, 64'hA5A5_0F0F_1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstp_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rstp_rsp_err",   64'(bus.rsp_err),   64'd0);
    check_eq("rstp_rsp_rdata", bus.rsp_rdata,      64'd0);
    check_eq("rstp_req_ready", 64'(bus.req_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    send(1'b0, 64'h18, 2'd3, 1'b1, 64'h0);
    drain();

    // Random traffic with random backpressure
    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.req_valid || acc) begin
        if ($urandom_range(0, 3) != 0) rand_req();
        else bus.req_valid = 1'b0;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    drain();
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter XLEN, default 64, data width in bits; legal value 64.
REQ-002 Parameter DEPTH, default 256, number of XLEN-bit words; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 64, byte-address width.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when high together with req_valid.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-012 req_wdata  in  XLEN  store data, right-aligned (LSBs).
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-015 rsp_rdata  out  XLEN  load result, extended per req_size and req_unsigned; 0 for stores and errors.
REQ-016 rsp_err  out  1  access faulted.

Function
REQ-017 Handshake rule: req_ready = !rsp_valid || rsp_ready (combinational); acceptance occurs when req_valid && req_ready at a rising edge.
REQ-018 Every accepted request produces exactly one response, with rsp_valid rising on the edge after acceptance (latency 1).
REQ-019 The response is held stable (rsp_valid, rsp_rdata, rsp_err) until rsp_ready is sampled high.
REQ-020 Acceptance and response consumption in the same edge: the new response replaces the old one, giving full throughput of one request per cycle.
REQ-021 Word index = req_addr[$clog2(DEPTH)+2:3]; byte lane = req_addr[2:0].
REQ-022 Out of range: req_addr >= DEPTH*8 gives rsp_err=1, suppresses the store, and forces rsp_rdata=0.
REQ-023 Store: writes only the 2^req_size bytes starting at the byte lane; other bytes are unchanged; memory is updated at the accept edge.
REQ-024 Load: reads at the accept edge, shifts the selected bytes to the LSBs, then extends to XLEN.
REQ-025 Read-after-write: a load accepted on the cycle after a store to the same word returns the updated data; no forwarding path is needed.
REQ-026 Memory array is not cleared by rst_n; its time-zero content is word i = i, for simulation and FPGA.

Reset
REQ-027 While rst_n is low: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1.
REQ-028 Reset during a pending response discards that response.
REQ-029 A store accepted before reset asserts remains committed in memory.

Configuration
REQ-030 Macro DMEM_ALIGN_CHK_EN defined: an access with (req_addr mod 2^req_size) != 0 is misaligned and gets rsp_err=1, no memory write, and rsp_rdata=0.
REQ-031 Macro DMEM_ALIGN_CHK_EN undefined: the low req_size address bits are cleared before use, and only out-of-range accesses set rsp_err.

Structure
REQ-032 Shared package dmem_pkg holds typedef mem_size_e (SZ_B, SZ_H, SZ_W, SZ_D) and constant XLEN_DEFAULT=64.
REQ-033 One sub-module, dmem_ext, holds the combinational byte-lane extract and sign/zero extension; it is instantiated once.

Verification
REQ-034 Store double 0x1122334455667788 at addr 0x10, then load double unsigned at 0x10 -> rsp_rdata=0x1122334455667788, rsp_err=0.
REQ-035 Store byte 0x80 at addr 0x13, then load byte signed at 0x13 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80; load double at 0x10 -> 0x1122334480667788.
REQ-036 Hold rsp_ready=0 for 3 cycles with a response pending -> req_ready=0, response stable; then back-to-back loads at 0x0 and 0x8 with rsp_ready=1 -> responses 0 and 1 on consecutive cycles.
REQ-037 Load half at addr 0x3 -> with DMEM_ALIGN_CHK_EN: rsp_err=1, rdata=0; without: data from addr 0x2, err=0.
REQ-038 Store at addr 0x800 with DEPTH=256 -> rsp_err=1, and a subsequent load of word 0 is unchanged (0).
REQ-039 Assert rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release, req_ready=1 and no stale response appears.
